fetch_queue: RTL and testbench

- Circular instruction buffer between the fetch stage (I-cache response) and the decoder.
- Decouples fetch from decode/rename stalls.
- Enqueues one fetched {pc, inst} pair per cycle and presents the oldest entry to the decoder through a valid/ready handshake.
- Flushed wholesale on a branch mispredict or redirect from the backend.

---
 rtl/fetch_queue.sv | 65 ++++++
 tb/tb_fetch_queue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: circular {pc, inst} buffer decoupling I-cache fetch from decode stalls.
// Rev 1.0
`default_nettype none

module fetch_queue #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [31:0]      enq_inst,
  input  logic [31:0]      enq_pc,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [31:0]      deq_inst,
  output logic [31:0]      deq_pc,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  logic [63:0]    mem [DEPTH];
  logic [PTR_W:0] head;
  logic [PTR_W:0] tail;
  logic           empty;
  logic           full;
  logic           push;
  logic           pop;

  // Extra wrap bit distinguishes full from empty when the indices coincide.
  assign empty     = (head == tail);
  assign full      = (head[PTR_W-1:0] == tail[PTR_W-1:0]) && (head[PTR_W] != tail[PTR_W]);
  assign count     = tail - head;
  assign enq_ready = !full;
  assign deq_valid = !empty;

  assign push = enq_valid && enq_ready && !flush;
  assign pop  = deq_valid && deq_ready && !flush;

  assign {deq_pc, deq_inst} = mem[head[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define contents.
  always_ff @(posedge clk) begin
    if (push) mem[tail[PTR_W-1:0]] <= {enq_pc, enq_inst};
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a queue-based reference model of fetch_queue.
// Rev 1.0
`default_nettype none

module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             enq_valid;
  logic             enq_ready;
  logic [31:0]      enq_inst;
  logic [31:0]      enq_pc;
  logic             deq_valid;
  logic             deq_ready;
  logic [31:0]      deq_inst;
  logic [31:0]      deq_pc;
  logic [PTR_W:0]   count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_inst  (enq_inst),
    .enq_pc    (enq_pc),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_inst  (deq_inst),
    .deq_pc    (deq_pc),
    .count     (count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en   = 1'b0;
  logic [63:0] model_q[$];
  bit          m_enq;
  bit          m_deq;
  logic [63:0] m_head;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of {pc, inst}, updated from the handshake rules.
  always @(negedge rst) model_q.delete();

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_enq = enq_valid && (model_q.size() < DEPTH);
      m_deq = deq_ready && (model_q.size() != 0);
      if (flush) begin
        model_q.delete();
      end else begin
        if (m_deq) void'(model_q.pop_front());
        if (m_enq) model_q.push_back({enq_pc, enq_inst});
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("deq_valid", 64'(deq_valid), 64'(model_q.size() != 0));
      chk("enq_ready", 64'(enq_ready), 64'(model_q.size() < DEPTH));
      chk("count",     64'(count),     64'(model_q.size()));
      if (model_q.size() != 0) begin
        m_head = model_q[0];
        chk("deq_pc",   64'(deq_pc),   64'(m_head[63:32]));
        chk("deq_inst", 64'(deq_inst), 64'(m_head[31:0]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_inst  = '0;
    enq_pc    = '0;
    deq_ready = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b1;

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("idle_deq_valid", 64'(deq_valid), 64'd0);
      chk("idle_enq_ready", 64'(enq_ready), 64'd1);
      chk("idle_count",     64'(count),     64'd0);
    end

    // Fill to full
    for (int i = 0; i < 8; i++) begin
      enq_valid = 1'b1;
      enq_pc    = 32'h1eceb000 + 32'(4 * i);
      enq_inst  = 32'h00000013 + 32'(i);
      cyc();
    end
    enq_pc   = 32'h1eceb020;
    enq_inst = 32'h0000001b;
    chk("full_count",     64'(count),     64'd8);
    chk("full_enq_ready", 64'(enq_ready), 64'd0);
    cyc();
    enq_valid = 1'b0;
    chk("ninth_ignored_count", 64'(count), 64'd8);

    // Drain in order
    deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 64'(deq_valid), 64'd1);
      chk("drain_pc",    64'(deq_pc),    64'(32'h1eceb000 + 32'(4 * i)));
      chk("drain_inst",  64'(deq_inst),  64'(32'h00000013 + 32'(i)));
      cyc();
    end
    chk("drained_valid", 64'(deq_valid), 64'd0);
    deq_ready = 1'b0;

    // Steady streaming across index wrap
    for (int i = 0; i < 20; i++) begin
      enq_valid = 1'b1;
      deq_ready = 1'b1;
      enq_pc    = 32'h00002000 + 32'(4 * i);
      enq_inst  = 32'h00a00093 + 32'(i);
      cyc();
      chk("stream_count", 64'(count),  64'd1);
      chk("stream_pc",    64'(deq_pc), 64'(32'h00002000 + 32'(4 * i)));
    end
    enq_valid = 1'b0;
    cyc();
    deq_ready = 1'b0;
    chk("stream_empty", 64'(count), 64'd0);

    // Full with simultaneous dequeue
    for (int i = 0; i < 8; i++) begin
      enq_valid = 1'b1;
      enq_pc    = 32'h00003000 + 32'(4 * i);
      enq_inst  = 32'h00100113 + 32'(i);
      cyc();
    end
    enq_pc    = 32'h00003020;
    deq_ready = 1'b1;
    cyc();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    chk("full_deq_count", 64'(count),  64'd7);
    chk("full_deq_head",  64'(deq_pc), 64'h3004);

    // Flush mid-stream
    deq_ready = 1'b1;
    cyc();
    cyc();
    deq_ready = 1'b0;
    chk("preflush_count", 64'(count), 64'd5);
    flush     = 1'b1;
    enq_valid = 1'b1;
    enq_pc    = 32'h00004000;
    cyc();
    flush     = 1'b0;
    enq_valid = 1'b0;
    chk("flush_count",     64'(count),     64'd0);
    chk("flush_deq_valid", 64'(deq_valid), 64'd0);
    chk("flush_enq_ready", 64'(enq_ready), 64'd1);
    enq_valid = 1'b1;
    enq_pc    = 32'h1eceb100;
    enq_inst  = 32'h00000013;
    cyc();
    enq_valid = 1'b0;
    chk("postflush_pc", 64'(deq_pc), 64'h1eceb100);
    deq_ready = 1'b1;
    cyc();
    deq_ready = 1'b0;

    // Async reset mid-operation
    for (int i = 0; i < 3; i++) begin
      enq_valid = 1'b1;
      enq_pc    = 32'h00005000 + 32'(4 * i);
      enq_inst  = 32'h00200193 + 32'(i);
      cyc();
    end
    enq_valid = 1'b0;
    chk("prereset_count", 64'(count), 64'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("async_deq_valid", 64'(deq_valid), 64'd0);
    chk("async_count",     64'(count),     64'd0);
    cyc();
    rst = 1'b1;
    enq_valid = 1'b1;
    enq_pc    = 32'h00006000;
    enq_inst  = 32'h00300213;
    cyc();
    enq_valid = 1'b0;
    chk("resume_count", 64'(count),  64'd1);
    chk("resume_pc",    64'(deq_pc), 64'h6000);
    deq_ready = 1'b1;
    cyc();
    deq_ready = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
